// File: rtl/ex_bus_arbiter.sv
// Round-robin arbiter sharing one single-port memory between NUM_REQ requesters, single or x2 (addr, addr+1) beats.
// Latency: grant -> o_mem_en 1 cycle; read data MEM_LAT+2 cycles after handshake, in issue order, tagged one-hot.
// Backpressure: combinational ready only in IDLE; x2 holds the bus one extra cycle; responses cannot be stalled.
module ex_bus_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 64,
  parameter int MEM_LAT = 2
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ-1:0]            i_req_we,
  input  logic [NUM_REQ-1:0]            i_req_x2,
  input  logic [NUM_REQ*ADDR_W-1:0]     i_req_addr,
  input  logic [NUM_REQ*2*DATA_W-1:0]   i_req_wdata,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic [NUM_REQ-1:0]            o_rsp_valid,
  output logic [DATA_W-1:0]             o_rsp_data,
  output logic                          o_mem_en,
  output logic                          o_mem_we,
  output logic [ADDR_W-1:0]             o_mem_addr,
  output logic [DATA_W-1:0]             o_mem_wdata,
  input  logic [DATA_W-1:0]             i_mem_rdata,
  output logic                          o_busy
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BEAT2 = 1'b1
  } state_t;

  state_t state, state_nxt;

  logic [IDX_W-1:0]  rr_ptr;
  logic [IDX_W-1:0]  grant_idx;
  logic              grant_any;
  logic              hs;
  logic [NUM_REQ-1:0] ready;

  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_lo;
  logic [DATA_W-1:0] sel_hi;
  logic              sel_we;
  logic              sel_x2;

  logic [IDX_W-1:0]  b2_tag;
  logic              b2_we;
  logic [ADDR_W-1:0] b2_addr;
  logic [DATA_W-1:0] b2_wdata;

  logic              mem_en_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [IDX_W-1:0]  mem_tag_q;

  logic [MEM_LAT:0]  pipe_vld;
  logic [IDX_W-1:0]  pipe_tag [0:MEM_LAT];
  logic [DATA_W-1:0] rsp_data_q;

  // First valid requester at or after the round-robin pointer, wrapping modulo NUM_REQ.
  always_comb begin
    int idx;
    logic [IDX_W-1:0] cand;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    cand      = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx  = (int'(rr_ptr) + k) % NUM_REQ;
      cand = idx[IDX_W-1:0];
      if (!grant_any && i_req_valid[cand]) begin
        grant_any = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign sel_addr = i_req_addr[grant_idx*ADDR_W +: ADDR_W];
  assign sel_lo   = i_req_wdata[grant_idx*2*DATA_W +: DATA_W];
  assign sel_hi   = i_req_wdata[grant_idx*2*DATA_W + DATA_W +: DATA_W];
  assign sel_we   = i_req_we[grant_idx];
  assign sel_x2   = i_req_x2[grant_idx];

  always_comb begin
    state_nxt = state;
    ready     = '0;
    hs        = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_any && !i_rst) begin
          ready[grant_idx] = 1'b1;
          hs               = 1'b1;
          if (sel_x2) begin
            state_nxt = ST_BEAT2;
          end
        end
      end
      ST_BEAT2: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign o_req_ready = ready;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
      end
    end
  end

  // Second beat is captured at handshake so the requester may drop or change its request immediately.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      b2_tag   <= '0;
      b2_we    <= 1'b0;
      b2_addr  <= '0;
      b2_wdata <= '0;
    end else if (hs && sel_x2) begin
      b2_tag   <= grant_idx;
      b2_we    <= sel_we;
      b2_addr  <= sel_addr + ADDR_W'(1);
      b2_wdata <= sel_hi;
    end
  end

  // Address/data/we hold their last values when no access is issued.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_tag_q   <= '0;
    end else begin
      mem_en_q <= 1'b0;
      if (hs) begin
        mem_en_q    <= 1'b1;
        mem_we_q    <= sel_we;
        mem_addr_q  <= sel_addr;
        mem_wdata_q <= sel_lo;
        mem_tag_q   <= grant_idx;
      end else if (state == ST_BEAT2) begin
        mem_en_q    <= 1'b1;
        mem_we_q    <= b2_we;
        mem_addr_q  <= b2_addr;
        mem_wdata_q <= b2_wdata;
        mem_tag_q   <= b2_tag;
      end
    end
  end

  assign o_mem_en    = mem_en_q;
  assign o_mem_we    = mem_we_q;
  assign o_mem_addr  = mem_addr_q;
  assign o_mem_wdata = mem_wdata_q;

  // Tag pipe runs in lockstep with memory latency; the stage before the last marks when rdata is valid.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      pipe_vld   <= '0;
      rsp_data_q <= '0;
      for (int i = 0; i <= MEM_LAT; i++) begin
        pipe_tag[i] <= '0;
      end
    end else begin
      pipe_vld    <= {pipe_vld[MEM_LAT-1:0], mem_en_q & ~mem_we_q};
      pipe_tag[0] <= mem_tag_q;
      for (int i = 1; i <= MEM_LAT; i++) begin
        pipe_tag[i] <= pipe_tag[i-1];
      end
      if (pipe_vld[MEM_LAT-1]) begin
        rsp_data_q <= i_mem_rdata;
      end
    end
  end

  always_comb begin
    o_rsp_valid = '0;
    if (pipe_vld[MEM_LAT]) begin
      o_rsp_valid[pipe_tag[MEM_LAT]] = 1'b1;
    end
  end

  assign o_rsp_data = rsp_data_q;
  assign o_busy     = (state == ST_BEAT2) | (|pipe_vld) | (mem_en_q & ~mem_we_q);

endmodule
